// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the hazard scoreboard unit
// Holds the FSM state encoding, stall-cause codes, forward-select codes,
// shadow stage indices and the youngest-match forward-select helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_DSTALL   = 2'b01,
        ST_MDU_WAIT = 2'b10,
        ST_FREEZE   = 2'b11
    } hz_state_e;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_DATA   = 2'b01;
    localparam logic [1:0] CAUSE_MDU    = 2'b10;
    localparam logic [1:0] CAUSE_FREEZE = 2'b11;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Shadow stage indices into the hit / load vectors
    localparam int SH_EX  = 0;
    localparam int SH_MEM = 1;
    localparam int SH_WB  = 2;

    // Select the source for the ID operand once it reaches EX: the producer
    // now in shadow EX will sit in EX/MEM, the one in MEM will sit in MEM/WB,
    // and the one in WB will already have written the register file.
    function automatic logic [1:0] fwd_pick(input logic [2:0] hit);
        logic [1:0] sel;
        sel = FWD_RF;
        if (hit[SH_EX]) begin
            sel = FWD_EXMEM;
        end else if (hit[SH_MEM]) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// rtl/hazard_shadow_pipe.sv - shadow EX/MEM/WB destination tracker
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   advance             shift the shadow pipe this edge (low while frozen)
//   issue               ID instruction enters EX this edge
//   kill_mem            EX entry is squashed instead of moving into MEM
//   issue_dst/load      destination and load flag of the issuing instruction
//   rs, rt              ID source registers to match
//   rs_hit, rt_hit      per-stage match vectors {WB, MEM, EX}
//   load_vec            per-stage valid load flags {WB, MEM, EX}
module hazard_shadow_pipe
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              issue,
    input  logic              kill_mem,
    input  logic [REG_AW-1:0] issue_dst,
    input  logic              issue_load,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    output logic [2:0]        rs_hit,
    output logic [2:0]        rt_hit,
    output logic [2:0]        load_vec
);

    logic [2:0]             valid_q;
    logic [2:0]             load_q;
    logic [2:0][REG_AW-1:0] dst_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            load_q  <= '0;
            dst_q   <= '0;
        end else if (advance) begin
            valid_q[SH_WB]  <= valid_q[SH_MEM];
            load_q[SH_WB]   <= load_q[SH_MEM];
            dst_q[SH_WB]    <= dst_q[SH_MEM];
            valid_q[SH_MEM] <= valid_q[SH_EX] & ~kill_mem;
            load_q[SH_MEM]  <= load_q[SH_EX];
            dst_q[SH_MEM]   <= dst_q[SH_EX];
            // $zero is never a real producer, so it never enters the shadow
            valid_q[SH_EX]  <= issue & (issue_dst != '0);
            load_q[SH_EX]   <= issue_load;
            dst_q[SH_EX]    <= issue_dst;
        end
    end

    always_comb begin
        rs_hit = '0;
        rt_hit = '0;
        for (int i = 0; i < 3; i++) begin
            rs_hit[i] = valid_q[i] & (dst_q[i] == rs);
            rt_hit[i] = valid_q[i] & (dst_q[i] == rt);
        end
    end

    assign load_vec = valid_q & load_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - pipeline hazard unit with shadow scoreboard
// Resolves RAW, load-use, MDU and memory-wait hazards plus branch/jump
// redirects for a 5-stage MIPS pipe. Optional feature macro: FORWARDING_EN
// (only load-use stalls; adds Fwd_A_Sel/Fwd_B_Sel).
// Ports:
//   Clk, Rst_n                       clock, asynchronous active-low reset
//   Valid_ID, Rs_ID, Rt_ID, UsesRs_ID, UsesRt_ID, RegWrite_ID, WriteReg_ID,
//   MemRead_ID, UsesHiLo_ID          decoded ID-stage instruction
//   Jump_EX, Branch_MEM              redirects resolved in EX / MEM
//   Mdu_Busy, Mem_Wait               multiply/divide busy, data memory wait
//   NotStall_PC, NotStall_IFID       PC and IF/ID write enables
//   Flush_ID, Flush_EX, Flush_MEM    clear IF/ID, ID/EX, EX/MEM
//   Stall_Cause                      previous cycle's winning condition
//   Stall_Count                      saturating data+MDU stall cycle count
//   Fwd_A_Sel, Fwd_B_Sel             forward selects (FORWARDING_EN only)
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW         = 5,
    parameter int LOAD_USE_DEPTH = 1,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   Valid_ID,
    input  logic [REG_AW-1:0]      Rs_ID,
    input  logic [REG_AW-1:0]      Rt_ID,
    input  logic                   UsesRs_ID,
    input  logic                   UsesRt_ID,
    input  logic                   RegWrite_ID,
    input  logic [REG_AW-1:0]      WriteReg_ID,
    input  logic                   MemRead_ID,
    input  logic                   UsesHiLo_ID,
    input  logic                   Jump_EX,
    input  logic                   Branch_MEM,
    input  logic                   Mdu_Busy,
    input  logic                   Mem_Wait,
    output logic                   NotStall_PC,
    output logic                   NotStall_IFID,
    output logic                   Flush_ID,
    output logic                   Flush_EX,
    output logic                   Flush_MEM,
    output logic [1:0]             Stall_Cause,
    output logic [STALL_CNT_W-1:0] Stall_Count
`ifdef FORWARDING_EN
    ,
    output logic [1:0]             Fwd_A_Sel,
    output logic [1:0]             Fwd_B_Sel
`endif
);

    hz_state_e  state_q;
    hz_state_e  next_state;
    logic [2:0] rs_hit;
    logic [2:0] rt_hit;
    logic [2:0] load_vec;
    logic       rs_use;
    logic       rt_use;
    logic       data_haz;
    logic       mdu_haz;
    logic       issue;
    logic       run_ns;
    logic [2:0] run_fl;

    assign rs_use  = Valid_ID & UsesRs_ID & (Rs_ID != '0);
    assign rt_use  = Valid_ID & UsesRt_ID & (Rt_ID != '0);
    assign mdu_haz = UsesHiLo_ID & Mdu_Busy;

    hazard_shadow_pipe #(
        .REG_AW (REG_AW)
    ) u_shadow (
        .clk        (Clk),
        .rst_n      (Rst_n),
        .advance    (~Mem_Wait),
        .issue      (issue),
        .kill_mem   (Branch_MEM),
        .issue_dst  (WriteReg_ID),
        .issue_load (MemRead_ID),
        .rs         (Rs_ID),
        .rt         (Rt_ID),
        .rs_hit     (rs_hit),
        .rt_hit     (rt_hit),
        .load_vec   (load_vec)
    );

`ifdef FORWARDING_EN
    logic [2:0] unfwd;
    logic [2:0] rs_young;
    logic [2:0] rt_young;
    logic       unused_load;

    // Loads whose data is not yet available to forward
    assign unfwd = {1'b0,
                    (LOAD_USE_DEPTH >= 2) ? load_vec[SH_MEM] : 1'b0,
                    load_vec[SH_EX]};
    // Only the youngest matching producer matters: an older load shadowed
    // by a younger ALU write to the same register is not a hazard.
    assign rs_young = rs_hit & ~{rs_hit[SH_MEM] | rs_hit[SH_EX], rs_hit[SH_EX], 1'b0};
    assign rt_young = rt_hit & ~{rt_hit[SH_MEM] | rt_hit[SH_EX], rt_hit[SH_EX], 1'b0};
    assign data_haz = (rs_use & |(rs_young & unfwd)) | (rt_use & |(rt_young & unfwd));
    assign Fwd_A_Sel = rs_use ? fwd_pick(rs_hit) : FWD_RF;
    assign Fwd_B_Sel = rt_use ? fwd_pick(rt_hit) : FWD_RF;
    assign unused_load = load_vec[SH_WB];
`else
    logic unused_cfg;

    // Register file is not write-through, so even a WB producer must drain
    assign data_haz   = (rs_use & |rs_hit) | (rt_use & |rt_hit);
    assign unused_cfg = ^{load_vec, (LOAD_USE_DEPTH == 2)};
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state = ST_RUN;
        issue      = 1'b0;
        run_ns     = 1'b1;
        run_fl     = 3'b000;
        if (Mem_Wait) begin
            next_state = ST_FREEZE;
            run_ns     = 1'b0;
        end else if (Branch_MEM) begin
            run_fl = 3'b111;
        end else if (Jump_EX) begin
            // jal in EX must still reach WB, so EX/MEM is left alone
            run_fl = 3'b110;
        end else if (data_haz) begin
            next_state = ST_DSTALL;
            run_ns     = 1'b0;
            run_fl     = 3'b010;
        end else if (mdu_haz) begin
            next_state = ST_MDU_WAIT;
            run_ns     = 1'b0;
            run_fl     = 3'b010;
        end else begin
            issue = Valid_ID & RegWrite_ID;
        end
    end

    // Reset forces enables and flushes high so the datapath clears too
    assign NotStall_PC   = run_ns | ~Rst_n;
    assign NotStall_IFID = run_ns | ~Rst_n;
    assign Flush_ID      = run_fl[2] | ~Rst_n;
    assign Flush_EX      = run_fl[1] | ~Rst_n;
    assign Flush_MEM     = run_fl[0] | ~Rst_n;

    always_comb begin
        Stall_Cause = CAUSE_NONE;
        case (state_q)
            ST_DSTALL:   Stall_Cause = CAUSE_DATA;
            ST_MDU_WAIT: Stall_Cause = CAUSE_MDU;
            ST_FREEZE:   Stall_Cause = CAUSE_FREEZE;
            default:     Stall_Cause = CAUSE_NONE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Stall_Count <= '0;
        end else if (((next_state == ST_DSTALL) || (next_state == ST_MDU_WAIT)) &&
                     (Stall_Count != '1)) begin
            Stall_Count <= Stall_Count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - scoreboard bench for hazard_scoreboard_unit
module tb_hazard_scoreboard_unit;

    localparam int          CNT_W   = 3;
    localparam int          CNT_MAX = 7;
    localparam logic [1:0]  W_RUN   = 2'b00;
    localparam logic [1:0]  W_DATA  = 2'b01;
    localparam logic [1:0]  W_MDU   = 2'b10;
    localparam logic [1:0]  W_FRZ   = 2'b11;
    localparam logic [1:0]  DC      = 2'b11;

    logic             Clk;
    logic             Rst_n;
    logic             Valid_ID;
    logic [4:0]       Rs_ID;
    logic [4:0]       Rt_ID;
    logic             UsesRs_ID;
    logic             UsesRt_ID;
    logic             RegWrite_ID;
    logic [4:0]       WriteReg_ID;
    logic             MemRead_ID;
    logic             UsesHiLo_ID;
    logic             Jump_EX;
    logic             Branch_MEM;
    logic             Mdu_Busy;
    logic             Mem_Wait;
    logic             NotStall_PC;
    logic             NotStall_IFID;
    logic             Flush_ID;
    logic             Flush_EX;
    logic             Flush_MEM;
    logic [1:0]       Stall_Cause;
    logic [CNT_W-1:0] Stall_Count;
`ifdef FORWARDING_EN
    logic [1:0]       Fwd_A_Sel;
    logic [1:0]       Fwd_B_Sel;
`endif

    hazard_scoreboard_unit #(
        .REG_AW         (5),
        .LOAD_USE_DEPTH (1),
        .STALL_CNT_W    (CNT_W)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Valid_ID      (Valid_ID),
        .Rs_ID         (Rs_ID),
        .Rt_ID         (Rt_ID),
        .UsesRs_ID     (UsesRs_ID),
        .UsesRt_ID     (UsesRt_ID),
        .RegWrite_ID   (RegWrite_ID),
        .WriteReg_ID   (WriteReg_ID),
        .MemRead_ID    (MemRead_ID),
        .UsesHiLo_ID   (UsesHiLo_ID),
        .Jump_EX       (Jump_EX),
        .Branch_MEM    (Branch_MEM),
        .Mdu_Busy      (Mdu_Busy),
        .Mem_Wait      (Mem_Wait),
        .NotStall_PC   (NotStall_PC),
        .NotStall_IFID (NotStall_IFID),
        .Flush_ID      (Flush_ID),
        .Flush_EX      (Flush_EX),
        .Flush_MEM     (Flush_MEM),
        .Stall_Cause   (Stall_Cause),
        .Stall_Count   (Stall_Count)
`ifdef FORWARDING_EN
        ,
        .Fwd_A_Sel     (Fwd_A_Sel),
        .Fwd_B_Sel     (Fwd_B_Sel)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        string       tag;
        logic        ns;
        logic [2:0]  fl;
        logic [1:0]  cause;
        logic [31:0] count;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    int         checks    = 0;
    int         errors    = 0;
    logic [1:0] prev_win  = W_RUN;
    int         exp_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            check({cur.tag, ".ns_pc"},   32'(NotStall_PC),   32'(cur.ns));
            check({cur.tag, ".ns_ifid"}, 32'(NotStall_IFID), 32'(cur.ns));
            check({cur.tag, ".flush"},   32'({Flush_ID, Flush_EX, Flush_MEM}), 32'(cur.fl));
            check({cur.tag, ".cause"},   32'(Stall_Cause),   32'(cur.cause));
            check({cur.tag, ".count"},   32'(Stall_Count),   cur.count);
`ifdef FORWARDING_EN
            if (cur.fa != DC) check({cur.tag, ".fwd_a"}, 32'(Fwd_A_Sel), 32'(cur.fa));
            if (cur.fb != DC) check({cur.tag, ".fwd_b"}, 32'(Fwd_B_Sel), 32'(cur.fb));
`endif
        end
    end

    // Push this cycle's expectation, then advance to just after the next edge
    task automatic step(input string tag, input logic ns, input logic [2:0] fl,
                        input logic [1:0] win, input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.tag   = tag;
        e.ns    = ns;
        e.fl    = fl;
        e.cause = prev_win;
        e.count = exp_count;
        e.fa    = fa;
        e.fb    = fb;
        q.push_back(e);
        prev_win = win;
        if ((win == W_DATA || win == W_MDU) && exp_count < CNT_MAX) exp_count++;
        @(posedge Clk);
        #1;
    endtask

    task automatic step_reset(input string tag);
        prev_win  = W_RUN;
        exp_count = 0;
        step(tag, 1'b1, 3'b111, W_RUN, DC, DC);
    endtask

    task automatic run_c(input string tag, input logic [1:0] fa, input logic [1:0] fb);
        step(tag, 1'b1, 3'b000, W_RUN, fa, fb);
    endtask

    task automatic stall_c(input string tag, input logic [1:0] win, input logic [1:0] fa, input logic [1:0] fb);
        step(tag, 1'b0, 3'b010, win, fa, fb);
    endtask

    task automatic id_idle();
        Valid_ID = 0; Rs_ID = 0; Rt_ID = 0; UsesRs_ID = 0; UsesRt_ID = 0;
        RegWrite_ID = 0; WriteReg_ID = 0; MemRead_ID = 0; UsesHiLo_ID = 0;
    endtask

    task automatic id_set(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                          input logic rw, input logic [4:0] wr, input logic mr, input logic hl);
        Valid_ID = 1; Rs_ID = rs; UsesRs_ID = urs; Rt_ID = rt; UsesRt_ID = urt;
        RegWrite_ID = rw; WriteReg_ID = wr; MemRead_ID = mr; UsesHiLo_ID = hl;
    endtask

    task automatic drain(input string tag);
        id_idle();
        for (int i = 0; i < 3; i++) run_c(tag, 2'b00, 2'b00);
    endtask

    initial begin
        Rst_n = 0; Jump_EX = 0; Branch_MEM = 0; Mdu_Busy = 0; Mem_Wait = 0;
        id_idle();
        @(posedge Clk);
        #1;
        step_reset("rst");
        Rst_n = 1;

        // load-use: lw $8 then add $10,$8,$9
        id_set(0, 0, 0, 0, 1, 8, 1, 0);  run_c("lu_lw", 2'b00, 2'b00);
        id_set(8, 1, 9, 1, 1, 10, 0, 0); stall_c("lu_stall", W_DATA, 2'b01, 2'b00);
`ifdef FORWARDING_EN
        run_c("lu_fwd", 2'b10, 2'b00);
`else
        stall_c("lu_mem", W_DATA, DC, DC);
        stall_c("lu_wb", W_DATA, DC, DC);
        run_c("lu_go", DC, DC);
`endif
        drain("lu_drain");

        // ALU RAW: add $8 then sub $11,$9,$8
        id_set(0, 0, 0, 0, 1, 8, 0, 0);  run_c("raw_add", 2'b00, 2'b00);
        id_set(9, 1, 8, 1, 1, 11, 0, 0);
`ifdef FORWARDING_EN
        run_c("raw_fwd", 2'b00, 2'b01);
`else
        for (int i = 0; i < 3; i++) stall_c("raw_stall", W_DATA, DC, DC);
        run_c("raw_go", DC, DC);
`endif
        drain("raw_drain");

        // taken branch outranks a load-use stall and kills the load
        id_set(0, 0, 0, 0, 1, 8, 1, 0);  run_c("br_lw", 2'b00, 2'b00);
        id_set(8, 1, 0, 0, 1, 10, 0, 0); Branch_MEM = 1;
        step("br_flush", 1'b1, 3'b111, W_RUN, DC, DC);
        Branch_MEM = 0;                  run_c("br_after", 2'b00, 2'b00);
        drain("br_drain");

        // jal resolved in EX: EX squashed, jal moves on to MEM
        id_set(0, 0, 0, 0, 1, 31, 0, 0); run_c("jal_issue", 2'b00, 2'b00);
        id_set(0, 0, 0, 0, 1, 5, 0, 0);  Jump_EX = 1;
        step("jal_flush", 1'b1, 3'b110, W_RUN, DC, DC);
        Jump_EX = 0;
        id_set(31, 1, 5, 1, 1, 6, 0, 0);
`ifdef FORWARDING_EN
        run_c("jal_mem", 2'b10, 2'b00);
`else
        stall_c("jal_mem", W_DATA, DC, DC);
        stall_c("jal_wb", W_DATA, DC, DC);
        run_c("jal_go", DC, DC);
`endif
        drain("jal_drain");

        // MDU stall interrupted by a 4-cycle memory freeze
        id_set(0, 0, 0, 0, 1, 12, 0, 0);   run_c("mdu_pre", 2'b00, 2'b00);
        id_set(13, 1, 14, 1, 0, 0, 0, 1);  Mdu_Busy = 1;
        stall_c("mdu_stall", W_MDU, 2'b00, 2'b00);
        Mem_Wait = 1;
        for (int i = 0; i < 4; i++) step("frz", 1'b0, 3'b000, W_FRZ, DC, DC);
        Mem_Wait = 0;
        id_set(12, 1, 14, 1, 0, 0, 0, 1);
`ifdef FORWARDING_EN
        stall_c("mdu_rel", W_MDU, 2'b10, 2'b00);
        Mdu_Busy = 0;
        run_c("mdu_done", 2'b00, 2'b00);
`else
        stall_c("mdu_rel", W_DATA, DC, DC);
        Mdu_Busy = 0;
        stall_c("mdu_wb", W_DATA, DC, DC);
        run_c("mdu_done", DC, DC);
`endif
        drain("mdu_drain");

        // $zero never creates a dependency
        id_set(0, 0, 0, 0, 1, 0, 0, 0);  run_c("r0_wr", 2'b00, 2'b00);
        id_set(0, 1, 0, 1, 1, 7, 0, 0);  run_c("r0_use", 2'b00, 2'b00);
        drain("r0_drain");

        // reset asserted while a load-use stall is in progress
        id_set(0, 0, 0, 0, 1, 8, 1, 0);  run_c("rs_lw", 2'b00, 2'b00);
        id_set(8, 1, 0, 0, 1, 10, 0, 0); stall_c("rs_stall", W_DATA, 2'b01, 2'b00);
        Rst_n = 0;
        step_reset("rst_mid");
        Rst_n = 1;
        run_c("rst_after", 2'b00, 2'b00);

        id_idle();
        run_c("idle", 2'b00, 2'b00);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
